cc_frame_collector: RTL

// - Sequential front/back end for the combinational Code Calculator (CC).
// - Accepts five 4-bit operands serially over a valid/ready handshake, latching opt with the first operand.
// - Presents the five operands and opt to CC as stable registers, captures CC's 10-bit result one cycle later.
// - Returns the result on a valid/ready output handshake. The CC instance lives outside this block, in the parent.

---
 rtl/cc_pkg.sv | 21 ++
 rtl/cc_frame_collector.sv | 116 +++++++++++
 2 files changed

// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared types and constants for the CC frame collector
package cc_pkg;

  localparam int DATA_W    = 4;
  localparam int NUM_OPS   = 5;
  localparam int OUT_W     = 10;
  localparam int CNT_W     = 3;
  localparam int GAP_LIMIT = 3;

  localparam int OPT_FORMULA = 2;
  localparam int OPT_ORDER   = 1;
  localparam int OPT_NORM    = 0;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL,
    OUT
  } cc_state_e;

endpackage

// File: rtl/cc_frame_collector.sv
// rtl/cc_frame_collector.sv - serial operand collector and result capture around the CC
// Optional gap abort: CC_GAP_ABORT_EN
module cc_frame_collector
  import cc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_opt,
  output logic [2:0]        cc_opt,
  output logic [DATA_W-1:0] cc_n0,
  output logic [DATA_W-1:0] cc_n1,
  output logic [DATA_W-1:0] cc_n2,
  output logic [DATA_W-1:0] cc_n3,
  output logic [DATA_W-1:0] cc_n4,
  input  logic [OUT_W-1:0]  cc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              abort
);

  cc_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] ops [NUM_OPS];

`ifdef CC_GAP_ABORT_EN
  localparam int GAP_W = $clog2(GAP_LIMIT + 1);
  logic [GAP_W-1:0] gap;
  logic             abort_q;
  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

  assign cc_n0 = ops[0];
  assign cc_n1 = ops[1];
  assign cc_n2 = ops[2];
  assign cc_n3 = ops[3];
  assign cc_n4 = ops[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cc_opt    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      for (int i = 0; i < NUM_OPS; i++) ops[i] <= '0;
`ifdef CC_GAP_ABORT_EN
      gap       <= '0;
      abort_q   <= 1'b0;
`endif
    end else begin
`ifdef CC_GAP_ABORT_EN
      abort_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cc_opt <= in_opt;
            ops[0] <= in_data;
            cnt    <= CNT_W'(1);
            state  <= COLLECT;
`ifdef CC_GAP_ABORT_EN
            gap    <= '0;
`endif
          end
        end
        COLLECT: begin
          if (in_valid && in_ready) begin
            ops[cnt] <= in_data;
`ifdef CC_GAP_ABORT_EN
            gap      <= '0;
`endif
            // cnt parks at the last index; it is cleared on the way back to IDLE
            if (cnt == CNT_W'(NUM_OPS - 1)) begin
              state    <= EVAL;
              in_ready <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef CC_GAP_ABORT_EN
          else if (gap == GAP_W'(GAP_LIMIT - 1)) begin
            abort_q <= 1'b1;
            gap     <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
`endif
        end
        EVAL: begin
          out_data  <= cc_out;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
